// File: rtl/aes_dec_iter_if.sv
// Handshake bundle for the iterative AES-128 decryptor:
// ciphertext and key in, plaintext out, plus a busy flag.
interface aes_dec_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] cipher;
  logic [0:127] key;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] plain;
  logic         busy;

  modport master (
    output in_valid, cipher, key, out_ready,
    input  in_ready, out_valid, plain, busy
  );

  modport slave (
    input  in_valid, cipher, key, out_ready,
    output in_ready, out_valid, plain, busy
  );
endinterface

// File: rtl/aes_dec_iter.sv
// Iterative AES-128 decryption core, one round per clock. The key schedule is
// run forward to round key 10 first, then stepped backwards one key per round.
module aes_dec_iter #(
  parameter int NR        = 10,
  parameter bit ZERO_IDLE = 1'b1
) (
  input logic           clk,
  input logic           rst,
  aes_dec_iter_if.slave bus
);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  if (NR != 10) begin : g_nr_check
    $error("aes_dec_iter: NR must be 10 (AES-128)");
  end

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_t;

  // Entry b sits at bits [2047-8b -: 8]; 2047-8b equals {~b, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[0] ? a : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
           (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t       state_reg, state_next;
  logic [127:0] st_reg, st_next;
  logic [127:0] rk_reg, rk_next;
  logic [127:0] plain_reg, plain_next;
  logic [3:0]   rcnt_reg, rcnt_next;

  logic [31:0]  w0, w1, w2, w3, w3p, sw_in, sw, rc_word, kw0;
  logic [3:0]   rc_idx;
  logic [127:0] rk_fwd, rk_inv, isb, ark, mix;

  // One shared SubWord serves both directions: w3 going forward, w3^w2 going back.
  assign {w0, w1, w2, w3} = rk_reg;
  assign w3p     = w3 ^ w2;
  assign sw_in   = (state_reg == ROUND) ? w3p : w3;
  assign rc_idx  = (state_reg == ROUND) ? rcnt_reg + 4'd1 : rcnt_reg;
  assign rc_word = {rcon(rc_idx), 24'h000000};

  for (genvar gi = 0; gi < 4; gi++) begin : g_subword
    assign sw[31-8*gi -: 8] = sbox(sw_in[31-8*((gi+1)%4) -: 8]);
  end

  assign kw0    = w0 ^ sw ^ rc_word;
  assign rk_fwd = {kw0, w1 ^ kw0, w2 ^ w1 ^ kw0, w3 ^ w2 ^ w1 ^ kw0};
  assign rk_inv = {kw0, w1 ^ w0, w2 ^ w1, w3p};

  // Byte gi = row (gi%4), column (gi/4); row r is rotated right by r.
  for (genvar gi = 0; gi < 16; gi++) begin : g_inv_round
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
    assign isb[127-8*gi -: 8] = inv_sbox(st_reg[127-8*SRC -: 8]);
  end

  assign ark = isb ^ rk_inv;

  for (genvar gi = 0; gi < 4; gi++) begin : g_inv_mix
    assign mix[127-32*gi -: 32] = inv_mix_col(ark[127-32*gi -: 32]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      st_reg    <= '0;
      rk_reg    <= '0;
      plain_reg <= '0;
      rcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      st_reg    <= st_next;
      rk_reg    <= rk_next;
      plain_reg <= plain_next;
      rcnt_reg  <= rcnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    st_next    = st_reg;
    rk_next    = rk_reg;
    plain_next = plain_reg;
    rcnt_next  = rcnt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          st_next    = bus.cipher;
          rk_next    = bus.key;
          rcnt_next  = 4'd1;
          state_next = KEYEXP;
        end
      end
      KEYEXP: begin
        rk_next   = rk_fwd;
        rcnt_next = rcnt_reg + 4'd1;
        if (rcnt_reg == 4'(NR)) begin
          st_next    = st_reg ^ rk_fwd;
          rcnt_next  = 4'(NR - 1);
          state_next = ROUND;
        end
      end
      ROUND: begin
        rk_next = rk_inv;
        if (rcnt_reg == 4'd0) begin
          st_next    = ark;
          plain_next = ark;
          state_next = DONE;
        end else begin
          st_next   = mix;
          rcnt_next = rcnt_reg - 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
          if (ZERO_IDLE) plain_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.busy      = (state_reg == KEYEXP) || (state_reg == ROUND);
  assign bus.plain     = plain_reg;

endmodule

// File: tb/tb_aes_dec_iter.sv
// Bench for aes_dec_iter: known-answer vectors, handshake corners, and a
// round trip through an independent software AES-128 encryptor.
module tb_aes_dec_iter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_dec_iter_if bus ();
  aes_dec_iter #(.NR(10), .ZERO_IDLE(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic [7:0] sbox_t [256];

  typedef struct {
    logic [127:0] key;
    logic [127:0] cipher;
    logic [127:0] plain;
    int           lat;
  } vec_t;
  vec_t vecs [3];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box from first principles: inverse in GF(2^8), then the affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, b);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   k [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      k[0] = k[0] ^ sbox_t[k[13]] ^ rc;
      k[1] = k[1] ^ sbox_t[k[14]];
      k[2] = k[2] ^ sbox_t[k[15]];
      k[3] = k[3] ^ sbox_t[k[12]];
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = gmul(rc, 8'h02);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = sbox_t[s[4*((c+r)%4)+r]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic status_check(input string name, input logic [2:0] exp_st);
    check({name, " status"}, 128'({bus.in_ready, bus.out_valid, bus.busy}), 128'(exp_st));
    check({name, " plain zero"}, bus.plain, 128'd0);
  endtask

  // Issue one block with out_ready left as the caller set it; returns at the first
  // out_valid cycle (or after 40 cycles). lat counts cycles from the accept cycle.
  task automatic run_block(input logic [127:0] k, input logic [127:0] c, input string name,
                           output logic [127:0] p, output int lat);
    @(negedge clk);
    check({name, " ready"}, 128'(bus.in_ready), 128'd1);
    bus.key = k;
    bus.cipher = c;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.key = ~k;
    bus.cipher = ~c;
    status_check({name, " busy"}, 3'b001);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    p = bus.plain;
    $display("xfer %s key=%h cipher=%h plain=%h lat=%0d", name, k, c, p, lat);
  endtask

  task automatic expect_idle(input string name);
    @(negedge clk);
    status_check(name, 3'b100);
  endtask

  initial begin
    logic [127:0] p, p1, p2, k, pt, ct;
    int lat, bad, v1, v2, acc2, npulse;

    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
    vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f, cipher: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                plain: 128'h00112233445566778899aabbccddeeff, lat: 21};
    vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, cipher: 128'h3925841d02dc09fbdc118597196a0b32,
                plain: 128'h3243f6a8885a308d313198a2e0370734, lat: 21};
    vecs[2] = '{key: 128'h0, cipher: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                plain: 128'h0, lat: 21};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.cipher = '0;
    bus.key = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    status_check("reset", 3'b100);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      run_block(vecs[i].key, vecs[i].cipher, $sformatf("vec%0d", i), p, lat);
      check($sformatf("vec%0d plain", i), p, vecs[i].plain);
      check($sformatf("vec%0d latency", i), 128'(lat), 128'(vecs[i].lat));
      expect_idle($sformatf("vec%0d release", i));
    end

    // Backpressure: result must sit still until out_ready rises.
    bus.out_ready = 1'b0;
    run_block(vecs[0].key, vecs[0].cipher, "backpressure", p, lat);
    check("bp plain", p, vecs[0].plain);
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.in_ready || bus.plain !== vecs[0].plain) bad++;
    end
    check("bp hold", 128'(bad), 128'd0);
    bus.out_ready = 1'b1;
    expect_idle("bp release");

    // Back-to-back with in_valid held high across the busy period.
    bus.key = vecs[0].key;
    bus.cipher = vecs[0].cipher;
    bus.in_valid = 1'b1;
    v1 = -1; v2 = -1; acc2 = -1; npulse = 0;
    p1 = '0; p2 = '0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus.key = vecs[1].key;
        bus.cipher = vecs[1].cipher;
      end
      if (bus.out_valid) begin
        npulse++;
        if (v1 < 0) begin v1 = cyc; p1 = bus.plain; end
        else if (v2 < 0) begin v2 = cyc; p2 = bus.plain; end
      end
      if (cyc > 1 && bus.in_ready && acc2 < 0) acc2 = cyc;
      if (acc2 >= 0 && cyc > acc2) bus.in_valid = 1'b0;
    end
    $display("xfer b2b first=%h at %0d second=%h at %0d accept2=%0d", p1, v1, p2, v2, acc2);
    check("b2b plain1", p1, vecs[0].plain);
    check("b2b plain2", p2, vecs[1].plain);
    check("b2b valid1 cycle", 128'(v1), 128'd21);
    check("b2b accept2 cycle", 128'(acc2), 128'd22);
    check("b2b valid2 cycle", 128'(v2), 128'd43);
    check("b2b pulse count", 128'(npulse), 128'd2);

    // Reset in the middle of a block.
    @(negedge clk);
    bus.key = vecs[0].key;
    bus.cipher = vecs[0].cipher;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("midrst busy before", 128'(bus.busy), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    status_check("midrst", 3'b100);
    rst = 1'b0;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid) bad++;
    end
    check("midrst no output", 128'(bad), 128'd0);
    $display("xfer midrst aborted block, valid_cycles=%0d", bad);
    run_block(vecs[1].key, vecs[1].cipher, "after reset", p, lat);
    check("after reset plain", p, vecs[1].plain);
    expect_idle("after reset release");

    // Round trip against the bench's own encryptor.
    for (int n = 0; n < 200; n++) begin
      k  = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      ct = aes_enc(k, pt);
      run_block(k, ct, $sformatf("rt%0d", n), p, lat);
      check($sformatf("rt%0d plain", n), p, pt);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
